// File: rtl/serial_tick_tx.sv
// rtl/serial_tick_tx.sv - tick-paced serial frame transmitter (even parity with SERIAL_TICK_TX_PARITY_EN)
module serial_tick_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    // Wide enough for up to 9 data bits and for the stop-bit count.
    localparam int CNT_W = 4;

`ifdef SERIAL_TICK_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t            state_q, state_d;
    logic              tick_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic              bit_en;

`ifdef SERIAL_TICK_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // One-clk strobe per rising edge of the upstream tick level.
    assign bit_en    = tick & ~tick_q;

    assign din_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign txd       = txd_q;
    assign done      = done_q;

    // Register state; tick_q resets high so a tick already high at release is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            tick_q   <= 1'b1;
            shift_q  <= '0;
            cnt_q    <= '0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef SERIAL_TICK_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            txd_q    <= txd_d;
            done_q   <= done_d;
`ifdef SERIAL_TICK_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Frame sequencing: each symbol advances only on bit_en, so a static tick stalls the frame.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        txd_d    = txd_q;
        done_d   = 1'b0;
`ifdef SERIAL_TICK_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A bit_en in the accept cycle is deliberately not used; START waits for the next one.
                if (din_valid) begin
                    shift_d  = din;
`ifdef SERIAL_TICK_TX_PARITY_EN
                    parity_d = ^din;
`endif
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_en) begin
                    txd_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_en) begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
`ifdef SERIAL_TICK_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TICK_TX_PARITY_EN
            S_PARITY: begin
                if (bit_en) begin
                    txd_d   = parity_q;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // First bit_en raises the line; done comes STOP_BITS bit_en periods later.
                if (bit_en) begin
                    if (cnt_q == CNT_W'(STOP_BITS)) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        txd_d   = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tick_tx.sv
// tb/tb_serial_tick_tx.sv - scoreboard bench for serial_tick_tx
`timescale 1ns/1ps
module tb_serial_tick_tx;

`ifdef SERIAL_TICK_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] din_a = 8'h00;
    logic [7:0] din_b = 8'h00;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;
    logic [1:0] ready_v, txd_v, busy_v, done_v;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    int         tick_cnt = 0;
    bit         tick_run = 1'b1;
    logic       tick_hold = 1'b0;

    always #5 clk = ~clk;

    serial_tick_tx u_dut_a (
        .clk(clk), .rst(rst), .tick(tick), .din(din_a), .din_valid(valid_a),
        .din_ready(ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    serial_tick_tx #(.DATA_W(8), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst(rst), .tick(tick), .din(din_b), .din_valid(valid_b),
        .din_ready(ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Mod-10 tick level: high 5 clk, low 5 clk; can be frozen at tick_hold.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (tick_run) begin
                tick_cnt = (tick_cnt + 1) % 10;
                tick = (tick_cnt < 5);
            end else begin
                tick = tick_hold;
            end
        end
    end

    // Decodes one frame per start bit, then pops the expected word and compares.
    task automatic monitor(input int idx);
        int          nsym;
        logic [15:0] got_bits, exp_bits;
        logic [7:0]  w;
        bit          aborted, stable, ctl_ok, done_ok, have;
        nsym = 1 + 8 + PAR + ((idx == 0) ? 1 : 2);
        forever begin
            @(negedge clk);
            if (rst && txd_v[idx] === 1'b0) begin
                aborted = 0; stable = 1; ctl_ok = 1; done_ok = 1; got_bits = '1;
                for (int n = 0; n <= nsym * 10 + 1; n++) begin
                    if (n > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1;
                        break;
                    end
                    if (n < nsym * 10) begin
                        if (n % 10 == 0) got_bits[n / 10] = txd_v[idx];
                        else if (txd_v[idx] !== got_bits[n / 10]) stable = 0;
                        if (done_v[idx] !== 1'b0) done_ok = 0;
                        if (busy_v[idx] !== 1'b1 || ready_v[idx] !== 1'b0) ctl_ok = 0;
                    end else if (n == nsym * 10) begin
                        if (done_v[idx] !== 1'b1) done_ok = 0;
                        if (busy_v[idx] !== 1'b0) ctl_ok = 0;
                    end else begin
                        if (done_v[idx] !== 1'b0) done_ok = 0;
                    end
                end
                if (!aborted) begin
                    have = 0;
                    w = 8'h00;
                    if (idx == 0 && exp_q0.size() > 0) begin w = exp_q0.pop_front(); have = 1; end
                    if (idx == 1 && exp_q1.size() > 0) begin w = exp_q1.pop_front(); have = 1; end
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected dut%0d: got frame 0x%0h expected none", idx, got_bits);
                    end else begin
                        exp_bits = '1;
                        exp_bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) exp_bits[1 + i] = w[i];
                        if (PAR == 1) exp_bits[9] = ^w;
                        check($sformatf("frame_bits dut%0d word %0h", idx, w), 32'(got_bits), 32'(exp_bits));
                        check($sformatf("symbol_10clk dut%0d word %0h", idx, w), 32'(stable), 32'd1);
                        check($sformatf("done_timing dut%0d word %0h", idx, w), 32'(done_ok), 32'd1);
                        check($sformatf("busy_ready dut%0d word %0h", idx, w), 32'(ctl_ok), 32'd1);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_accept_a(output bit saw_done);
        bit ok;
        ok = 0;
        saw_done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready_v[0] && valid_a) begin
                saw_done = done_v[0];
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            fail_now("accept_timeout dut0");
        end
    endtask

    task automatic send_a(input logic [7:0] w);
        bit sd;
        @(posedge clk); #1;
        din_a = w;
        valid_a = 1'b1;
        exp_q0.push_back(w);
        wait_accept_a(sd);
        valid_a = 1'b0;
        din_a = ~w;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && busy_v == 2'b00) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_txd_low_a();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd_v[0] === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("start_bit_timeout dut0");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sd;
        bit ok;
        int lat;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txd", 32'(txd_v[0]), 32'd1);
        check("reset_busy", 32'(busy_v[0]), 32'd0);
        check("reset_done", 32'(done_v[0]), 32'd0);
        check("reset_ready", 32'(ready_v[0]), 32'd1);
        check("reset_txd_b", 32'(txd_v[1]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single frames
        send_a(8'hA5);
        wait_drain();
        send_a(8'hFF);
        wait_drain();

        // Back-to-back with din_valid held high
        @(posedge clk); #1;
        din_a = 8'hA5;
        valid_a = 1'b1;
        exp_q0.push_back(8'hA5);
        wait_accept_a(sd);
        din_a = 8'h3C;
        exp_q0.push_back(8'h3C);
        wait_accept_a(sd);
        check("b2b_accept_in_done_cycle", 32'(sd), 32'd1);
        valid_a = 1'b0;
        din_a = 8'h00;
        wait_drain();

        // Reset during the 4th data bit aborts the frame
        @(posedge clk); #1;
        din_a = 8'h5B;
        valid_a = 1'b1;
        wait_accept_a(sd);
        valid_a = 1'b0;
        wait_txd_low_a();
        repeat (45) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_txd", 32'(txd_v[0]), 32'd1);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_done", 32'(done_v[0]), 32'd0);
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || txd_v[0] !== 1'b1) ok = 0;
        end
        check("abort_hold_quiet", 32'(ok), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        send_a(8'h81);
        wait_drain();

        // Tick high across reset release and held: frame stalls in START
        @(posedge clk); #1;
        rst = 1'b0;
        tick_run = 1'b0;
        tick_hold = 1'b1;
        din_a = 8'h5A;
        valid_a = 1'b1;
        exp_q0.push_back(8'h5A);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_accept_a(sd);
        valid_a = 1'b0;
        ok = 1;
        repeat (30) begin
            @(negedge clk);
            if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b1) ok = 0;
        end
        check("tick_static_stall", 32'(ok), 32'd1);
        tick_cnt = 4;
        tick_run = 1'b1;
        wait_drain();

        // Two stop bits; accept lands on a bit_en cycle, which must be ignored
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (tick_cnt == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("bit_en_search_timeout");
        din_b = 8'h00;
        valid_b = 1'b1;
        exp_q1.push_back(8'h00);
        @(posedge clk); #1;
        valid_b = 1'b0;
        din_b = 8'hFF;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (txd_v[1] === 1'b0) begin
                lat = n;
                break;
            end
        end
        check("coincident_bit_en_latency", 32'(lat), 32'd10);
        wait_drain();

        @(posedge clk); #1;
        din_b = 8'hC3;
        valid_b = 1'b1;
        exp_q1.push_back(8'hC3);
        @(posedge clk); #1;
        valid_b = 1'b0;
        wait_drain();

        check("queue0_empty", 32'(exp_q0.size()), 32'd0);
        check("queue1_empty", 32'(exp_q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
